// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the sequential ALU: operation codes, FSM state
//   encoding and the accumulator width helper used by the multiplier.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_XNOR = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Full product width of a WIDTH x WIDTH multiply.
  function automatic int acc_w(input int width);
    return 2 * width;
  endfunction

  // MUL and MULH share the 101x prefix; both go through the iterative engine.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op[3:1] == 3'b101);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
//   Request/result bundle between the CPU control unit and alu_seq.
//   master: drives start, ALU_OP, A, B; observes F, flags, busy, done.
//   slave : the ALU side.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALU_OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] F;
  logic             ZF;
  logic             OF;
  logic             CF;
  logic             busy;
  logic             done;

  modport master (
    output start, ALU_OP, A, B,
    input  F, ZF, OF, CF, busy, done
  );

  modport slave (
    input  start, ALU_OP, A, B,
    output F, ZF, OF, CF, busy, done
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter
//   Unsigned shift-add multiplier, one multiplier bit per step.
//   clk, rst  : clock, asynchronous active-high reset (clears all state)
//   load      : capture a/b, clear accumulator and counter
//   step      : perform one iteration
//   a, b      : multiplicand / multiplier
//   prod_next : accumulator value including the current step's partial add,
//               so the final product is available in the same cycle as the
//               last step
//   last      : the current step is iteration WIDTH
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int ACC_W = acc_w(WIDTH),
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [ACC_W-1:0] prod_next,
  output logic             last
);

  logic [ACC_W-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [ACC_W-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;

  always_comb begin
    prod_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last      = (cnt_q == SHW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= ACC_W'(a);
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= prod_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SHW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Registered-result ALU with an iterative WIDTH-cycle multiplier.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_seq_if slave port
//     start/ALU_OP/A/B : request, sampled only while busy=0
//     F, ZF, OF, CF    : registered result and flags, held between completions
//     busy             : multiply in progress
//     done             : one-cycle pulse when F/flags were just updated
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int ACC_W = acc_w(WIDTH);

  state_t state_q, state_d;

  logic             load, step, upd_single, upd_mul;
  logic             mulh_q;
  logic [ACC_W-1:0] prod_next;
  logic             mul_last;

  logic [WIDTH-1:0] res_f;
  logic             res_of, res_cf;
  logic [WIDTH-1:0] mul_f;
  logic             mul_of;

  logic [WIDTH-1:0] f_p0;
  logic             zf_p0, of_p0, cf_p0, vld_p0;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .a         (bus.A),
    .b         (bus.B),
    .prod_next (prod_next),
    .last      (mul_last)
  );

  // Single-cycle operations
  logic [WIDTH:0]          add_x;
  logic [WIDTH-1:0]        sub_r;
  logic signed [WIDTH-1:0] b_s;
  logic [SHW-1:0]          shamt;

  always_comb begin
    res_f  = '0;
    res_of = 1'b0;
    res_cf = 1'b0;
    add_x  = {1'b0, bus.A} + {1'b0, bus.B};
    sub_r  = bus.A - bus.B;
    b_s    = bus.B;
    shamt  = bus.A[SHW-1:0];
    case (bus.ALU_OP)
      OP_AND:  res_f = bus.A & bus.B;
      OP_OR:   res_f = bus.A | bus.B;
      OP_XOR:  res_f = bus.A ^ bus.B;
      OP_XNOR: res_f = ~(bus.A ^ bus.B);
      OP_ADD: begin
        res_f  = add_x[WIDTH-1:0];
        res_cf = add_x[WIDTH];
        res_of = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                 (add_x[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        res_f  = sub_r;
        res_cf = (bus.A < bus.B);
        res_of = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                 (sub_r[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SLTU: res_f = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_SLL:  res_f = bus.B << shamt;
      OP_SRL:  res_f = bus.B >> shamt;
      OP_SRA:  res_f = b_s >>> shamt;
      default: res_f = '0;  // reserved codes; MUL codes never take this path
    endcase
  end

  // Multiply result: half select and overflow from the final product
  always_comb begin
    mul_f  = mulh_q ? prod_next[ACC_W-1:WIDTH] : prod_next[WIDTH-1:0];
    mul_of = |prod_next[ACC_W-1:WIDTH];
  end

  // Control FSM
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    upd_single = 1'b0;
    upd_mul    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_mul_op(bus.ALU_OP)) begin
            load    = 1'b1;
            state_d = ST_MUL;
          end else begin
            upd_single = 1'b1;
          end
        end
      end
      ST_MUL: begin
        step = 1'b1;
        if (mul_last) begin
          upd_mul = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mulh_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) mulh_q <= bus.ALU_OP[0];
    end
  end

  // ---- stage p0: registered result, flags and done ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_p0   <= '0;
      zf_p0  <= 1'b0;
      of_p0  <= 1'b0;
      cf_p0  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= upd_single | upd_mul;
      if (upd_single) begin
        f_p0  <= res_f;
        zf_p0 <= (res_f == '0);
        of_p0 <= res_of;
        cf_p0 <= res_cf;
      end else if (upd_mul) begin
        f_p0  <= mul_f;
        zf_p0 <= (mul_f == '0);
        of_p0 <= mul_of;
        cf_p0 <= 1'b0;
      end
    end
  end

  assign bus.F    = f_p0;
  assign bus.ZF   = zf_p0;
  assign bus.OF   = of_p0;
  assign bus.CF   = cf_p0;
  assign bus.done = vld_p0;
  assign bus.busy = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.ALU_OP = op;
    bus.A      = a;
    bus.B      = b;
    tick();
    bus.start  = 1'b0;
  endtask

  // Waits for busy to fall, counting cycles; an ADD start is pulsed and the
  // operands are scrambled part-way through to prove they are not re-sampled.
  task automatic wait_mul(output int n, output int done_early);
    n = 0;
    done_early = 0;
    while (bus.busy && n < 64) begin
      if (n == 3) begin
        bus.start = 1'b1; bus.ALU_OP = OP_ADD; bus.A = 32'h1; bus.B = 32'h2;
      end else begin
        bus.start = 1'b0;
        if (n == 4) begin bus.A = 32'hDEADBEEF; bus.B = 32'h12345678; end
      end
      tick();
      n++;
      if (bus.busy && bus.done) done_early++;
    end
    bus.start = 1'b0;
  endtask

  int n, early;

  initial begin
    bus.start = 1'b0; bus.ALU_OP = 4'h0; bus.A = '0; bus.B = '0;
    tick(); tick();
    check("rst_F", bus.F, 0);
    check("rst_flags", {bus.ZF, bus.OF, bus.CF}, 0);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
    rst = 1'b0;
    tick();

    issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001);
    check("add_done", bus.done, 1);
    check("add_F", bus.F, 32'h80000000);
    check("add_ZOC", {bus.ZF, bus.OF, bus.CF}, 3'b010);
    tick();
    check("add_done_low", bus.done, 0);
    check("add_F_hold", bus.F, 32'h80000000);

    issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001);
    check("addc_F", bus.F, 0);
    check("addc_ZOC", {bus.ZF, bus.OF, bus.CF}, 3'b101);

    issue(OP_SUB, 32'h00000000, 32'h00000001);
    check("sub_F", bus.F, 32'hFFFFFFFF);
    check("sub_ZOC", {bus.ZF, bus.OF, bus.CF}, 3'b001);

    issue(OP_SRA, 32'd4, 32'h80000000);
    check("sra_F", bus.F, 32'hF8000000);
    issue(OP_SRL, 32'd4, 32'h80000000);
    check("srl_F", bus.F, 32'h08000000);
    issue(OP_SLL, 32'd36, 32'h1);
    check("sll_F", bus.F, 32'h10);

    issue(OP_XNOR, 32'hFFFF0000, 32'h0F0F0F0F);
    check("xnor_F", bus.F, 32'h0F0FF0F0);
    issue(OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
    check("and_F", bus.F, 32'h0F0F0000);
    issue(OP_OR, 32'hFFFF0000, 32'h0F0F0F0F);
    check("or_F", bus.F, 32'hFFFF0F0F);
    issue(OP_SLTU, 32'h1, 32'h2);
    check("sltu_lt", bus.F, 1);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h1);
    check("sltu_ge", {bus.F, bus.ZF}, {32'h0, 1'b1});

    issue(4'b1110, 32'h5, 32'h7);
    check("rsv_done", bus.done, 1);
    check("rsv_F", bus.F, 0);
    check("rsv_ZOC", {bus.ZF, bus.OF, bus.CF}, 3'b100);
    tick();

    issue(OP_MUL, 32'h00010000, 32'h00010000);
    check("mul_busy", {bus.busy, bus.done}, 2'b10);
    wait_mul(n, early);
    check("mul_latency", n, 32);
    check("mul_no_early_done", early, 0);
    check("mul_done", {bus.busy, bus.done}, 2'b01);
    check("mul_F", bus.F, 0);
    check("mul_ZOC", {bus.ZF, bus.OF, bus.CF}, 3'b110);

    issue(OP_XOR, 32'hF0F0F0F0, 32'hFFFFFFFF);
    check("b2b_xor_F", bus.F, 32'h0F0F0F0F);
    check("b2b_xor_done", bus.done, 1);

    issue(OP_MULH, 32'h00010000, 32'h00010000);
    wait_mul(n, early);
    check("mulh_latency", n, 32);
    check("mulh_F", bus.F, 32'h1);
    check("mulh_ZOC", {bus.ZF, bus.OF, bus.CF}, 3'b010);

    issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_mul(n, early);
    check("mul_max_F", bus.F, 32'h00000001);
    check("mul_max_OF", bus.OF, 1);
    issue(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_mul(n, early);
    check("mulh_max_F", bus.F, 32'hFFFFFFFE);
    issue(OP_MUL, 32'd3, 32'd5);
    wait_mul(n, early);
    check("mul_small_F", bus.F, 32'd15);
    check("mul_small_ZOC", {bus.ZF, bus.OF, bus.CF}, 3'b000);

    issue(OP_MUL, 32'd7, 32'd9);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_F", bus.F, 0);
    check("rst_mid_flags", {bus.ZF, bus.OF, bus.CF}, 0);
    check("rst_mid_busy_done", {bus.busy, bus.done}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) n++;
    end
    check("rst_abort_no_done", n, 0);
    issue(OP_ADD, 32'd2, 32'd3);
    check("post_rst_add", {bus.F, bus.done}, {32'd5, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
